// File: rtl/samp_iter_pkg.sv
// Shared definitions for the sample iterator: FSM states, subsample encodings
// and the helper that turns a subsample mode into a step shift.
package samp_iter_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Returns k such that step = 1.0 >> k; an unexpected encoding falls back to 1x.
    function automatic logic [1:0] subSampleShift(input logic [3:0] subSample);
        logic [1:0] k;
        case (subSample)
            SS_4X:   k = 2'd1;
            SS_16X:  k = 2'd2;
            SS_64X:  k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/samp_lane_gen.sv
// Combinational lane generator: spreads SAMPS sample x positions one step apart
// from a base x and flags the lanes that still lie inside the box.
module samp_lane_gen
    import samp_iter_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int SAMPS  = 4
) (
    input  logic signed [SIGFIG:0]   posX_i,
    input  logic signed [SIGFIG:0]   step_i,
    input  logic signed [SIGFIG:0]   urX_i,
    output logic [SIGFIG-1:0]        laneX_o [SAMPS],
    output logic [SAMPS-1:0]         laneValid_o
);

    logic signed [SIGFIG:0] acc;

    // One extra bit keeps lanes past the right edge from wrapping back inside the box.
    always_comb begin
        acc         = posX_i;
        laneValid_o = '0;
        for (int i = 0; i < SAMPS; i++) begin
            laneX_o[i]     = acc[SIGFIG-1:0];
            laneValid_o[i] = (acc <= urX_i);
            acc            = acc + step_i;
        end
    end

endmodule

// File: rtl/samp_iter_sched.sv
// Sample iterator: walks a triangle's bounding box in groups of SAMPS lanes per cycle.
// Define SAMP_ITER_PERF_EN to add the triangle/group performance counters.
module samp_iter_sched
    import samp_iter_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int SAMPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic [3:0]               subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic [SIGFIG-1:0]        tri_R14S [VERTS][AXIS],
    output logic [SIGFIG-1:0]        sample_R14S [2][SAMPS],
    output logic                     validSamp_R14H,
    output logic [SAMPS-1:0]         laneValid_R14H
`ifdef SAMP_ITER_PERF_EN
    ,
    output logic [31:0]              triCount_RnnU,
    output logic [31:0]              groupCount_RnnU
`endif
);

    localparam int W = SIGFIG + 1;
    localparam logic signed [W-1:0] ONE     = W'(64'd1 << RADIX);
    localparam logic signed [W-1:0] SAMPS_W = W'(SAMPS);

    iter_state_t state_q, state_d;

    logic [SIGFIG-1:0]     tri_q [VERTS][AXIS];
    logic signed [W-1:0]   llX_q, llX_d;
    logic signed [W-1:0]   urX_q, urX_d;
    logic signed [W-1:0]   urY_q, urY_d;
    logic signed [W-1:0]   posX_q, posX_d;
    logic signed [W-1:0]   posY_q, posY_d;

    logic [SIGFIG-1:0]     sampX_q [SAMPS];
    logic [SIGFIG-1:0]     sampY_q;
    logic [SAMPS-1:0]      laneValid_q;
    logic                  validSamp_q;
    logic                  halt_q;

    logic signed [W-1:0]   step;
    logic signed [W-1:0]   grpStep;
    logic signed [W-1:0]   inLlX, inLlY, inUrX, inUrY;
    logic                  boxLegal;
    logic                  advX, advY, lastGroup;
    logic                  accept;
    logic                  haltD;
    logic [SIGFIG-1:0]     laneXNext [SAMPS];
    logic [SAMPS-1:0]      laneValidNext;

    assign step    = ONE >> subSampleShift(subSample_RnnnnU);
    assign grpStep = step * SAMPS_W;

    assign inLlX = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
    assign inLlY = {box_R13S[0][1][SIGFIG-1], box_R13S[0][1]};
    assign inUrX = {box_R13S[1][0][SIGFIG-1], box_R13S[1][0]};
    assign inUrY = {box_R13S[1][1][SIGFIG-1], box_R13S[1][1]};

    assign boxLegal  = (inUrX >= inLlX) && (inUrY >= inLlY);
    assign advX      = (posX_q + grpStep) <= urX_q;
    assign advY      = (posY_q + step) <= urY_q;
    assign lastGroup = !advX && !advY;

    // A new triangle is taken when idle, or on the final group so back-to-back triangles leave no bubble.
    assign accept = validTri_R13H && boxLegal && ((state_q == WAIT) || lastGroup);

    always_comb begin
        state_d = state_q;
        llX_d   = llX_q;
        urX_d   = urX_q;
        urY_d   = urY_q;
        posX_d  = posX_q;
        posY_d  = posY_q;
        if (accept) begin
            state_d = TEST;
            llX_d   = inLlX;
            urX_d   = inUrX;
            urY_d   = inUrY;
            posX_d  = inLlX;
            posY_d  = inLlY;
        end else if (state_q == TEST) begin
            if (advX) begin
                posX_d = posX_q + grpStep;
            end else if (advY) begin
                posX_d = llX_q;
                posY_d = posY_q + step;
            end else begin
                state_d = WAIT;
            end
        end
    end

    // Outputs are registered, so the halt decision looks ahead at the group that will be shown next.
    assign haltD = (state_d == WAIT) ||
                   (((posX_d + grpStep) > urX_d) && ((posY_d + step) > urY_d));

    samp_lane_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_laneGen (
        .posX_i      (posX_d),
        .step_i      (step),
        .urX_i       (urX_d),
        .laneX_o     (laneXNext),
        .laneValid_o (laneValidNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT;
            llX_q       <= '0;
            urX_q       <= '0;
            urY_q       <= '0;
            posX_q      <= '0;
            posY_q      <= '0;
            sampY_q     <= '0;
            laneValid_q <= '0;
            validSamp_q <= 1'b0;
            halt_q      <= 1'b1;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_q[v][a] <= '0;
                end
            end
            for (int i = 0; i < SAMPS; i++) begin
                sampX_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            llX_q       <= llX_d;
            urX_q       <= urX_d;
            urY_q       <= urY_d;
            posX_q      <= posX_d;
            posY_q      <= posY_d;
            sampY_q     <= posY_d[SIGFIG-1:0];
            validSamp_q <= (state_d == TEST);
            laneValid_q <= (state_d == TEST) ? laneValidNext : '0;
            halt_q      <= haltD;
            if (accept) begin
                for (int v = 0; v < VERTS; v++) begin
                    for (int a = 0; a < AXIS; a++) begin
                        tri_q[v][a] <= tri_R13S[v][a];
                    end
                end
            end
            for (int i = 0; i < SAMPS; i++) begin
                sampX_q[i] <= laneXNext[i];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VERTS; v++) begin
            for (int a = 0; a < AXIS; a++) begin
                tri_R14S[v][a] = tri_q[v][a];
            end
        end
        for (int i = 0; i < SAMPS; i++) begin
            sample_R14S[0][i] = sampX_q[i];
            sample_R14S[1][i] = sampY_q;
        end
    end

    assign validSamp_R14H = validSamp_q;
    assign laneValid_R14H = laneValid_q;
    assign halt_RnnnnL    = halt_q;

`ifdef SAMP_ITER_PERF_EN
    logic [31:0] triCount_q;
    logic [31:0] groupCount_q;

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            triCount_q   <= '0;
            groupCount_q <= '0;
        end else begin
            if (accept) begin
                triCount_q <= triCount_q + 32'd1;
            end
            if (validSamp_q) begin
                groupCount_q <= groupCount_q + 32'd1;
            end
        end
    end

    assign triCount_RnnU   = triCount_q;
    assign groupCount_RnnU = groupCount_q;
`endif

endmodule

// File: doc/samp_iter_sched.md
SAMP_ITER_SCHED -- requirements
Module: samp_iter_sched

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per fixed-point coordinate.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits (1.0 = 1024).
REQ-003 SHALL have parameter VERTS, default 3, meaning vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, meaning axes per vertex.
REQ-005 SHALL have parameter SAMPS, default 4, meaning sample lanes emitted per cycle along x.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port tri_R13S, input, [VERTS][AXIS]xSIGFIG signed, meaning the triangle from the bbox stage.
REQ-009 SHALL have port box_R13S, input, [2][2]xSIGFIG signed, meaning [0]=lower-left (x,y) and [1]=upper-right (x,y), sample-grid aligned.
REQ-010 SHALL have port validTri_R13H, input, 1, meaning the triangle and box are valid.
REQ-011 SHALL have port subSample_RnnnnU, input, 4, one-hot: 1000=1x, 0100=4x, 0010=16x, 0001=64x; quasi-static, changed only while idle.
REQ-012 SHALL have port halt_RnnnnL, output, 1, active-low: upstream holds its outputs while low.
REQ-013 SHALL have port tri_R14S, output, [VERTS][AXIS]xSIGFIG, meaning the latched triangle.
REQ-014 SHALL have port sample_R14S, output, [2][SAMPS]xSIGFIG, meaning per-lane sample x ([0]) and y ([1]).
REQ-015 SHALL have port validSamp_R14H, output, 1, meaning the sample group is valid.
REQ-016 SHALL have port laneValid_R14H, output, SAMPS, meaning the per-lane mask: lane x <= box upper-right x.

Function
REQ-017 SHALL implement states WAIT and TEST; state, tri, box and sample position are registered.
REQ-018 SHALL set step = 1 << (RADIX - k), where k = 0/1/2/3 for 1x/4x/16x/64x.
REQ-019 In WAIT with validTri_R13H=1 and a legal box (ur.x >= ll.x and ur.y >= ll.y), SHALL latch tri/box, set position = (ll.x, ll.y) and enter TEST; the first group is valid the next cycle (latency 1).
REQ-020 In WAIT with an illegal box, SHALL drop the triangle and stay in WAIT.
REQ-021 In TEST, SHALL drive lane i at x = pos.x + i*step and y = pos.y, with validSamp_R14H=1.
REQ-022 SHALL advance as follows: if pos.x + SAMPS*step <= ur.x then pos.x += SAMPS*step; else if pos.y + step <= ur.y then pos.x = ll.x and pos.y += step; else the group is last.
REQ-023 On the last group, SHALL return to WAIT, or directly restart per REQ-019 if validTri_R13H=1 (no bubble).
REQ-024 SHALL drive halt_RnnnnL = 1 in WAIT and on the last TEST group, and 0 otherwise.
REQ-025 SHALL compute arithmetic at SIGFIG+1 bits so that lane x beyond ur.x never wraps; lane outputs are truncated to SIGFIG.
REQ-026 SHALL drive validSamp_R14H=0 and laneValid_R14H=0 in WAIT.

Reset
REQ-027 On rst=1 (async), SHALL force state=WAIT, validSamp_R14H=0, laneValid_R14H=0, halt_RnnnnL=1, and all tri/sample/position registers to 0; a reset mid-iteration abandons the triangle.

Configuration
REQ-028 With SAMP_ITER_PERF_EN defined, SHALL add outputs triCount_RnnU[31:0] (accepted triangles) and groupCount_RnnU[31:0] (valid groups), both wrapping, both reset to 0.
REQ-029 Without SAMP_ITER_PERF_EN, these ports and their counters SHALL be absent.

Structure
REQ-030 Package samp_iter_pkg SHALL hold the state enum (WAIT, TEST), the subsample one-hot encodings and a step-shift function.
REQ-031 Sub-module samp_lane_gen (combinational) SHALL compute lane x values and laneValid from pos.x, step and ur.x.

Verification
REQ-032 Reset check: rst pulse mid-frame -> validSamp=0, halt=1, and laneValid=0 the same cycle.
REQ-033 1x, box (0,0)-(3072,1024): validTri at cycle 0 -> groups at cycles 1 and 2 with y=0 then 1024 and lanes x=0,1024,2048,3072 with mask 1111; halt=0 at cycle 1 only.
REQ-034 1x, box (0,0)-(1024,0) -> one group with mask 0011, and halt stays 1.
REQ-035 4x, box (0,0)-(512,512) -> two groups (y=0, y=512), x=0,512,1024,1536, mask 0011.
REQ-036 Second triangle presented on the last group's cycle -> its first group follows on the next cycle with no idle cycle; an illegal box (ll.x=2048, ur.x=1024) -> no validSamp.
REQ-037 With SAMP_ITER_PERF_EN, after REQ-033 -> triCount=1 and groupCount=2.
